// File: rtl/demux4_pkg.sv
// Shared types and constants for the registered 1-to-4 demultiplexer.
// Destination codes map 2'b00..2'b11 onto output slots q00..q11.
package demux4_pkg;

    typedef logic [1:0] dst_t;

    localparam dst_t DST_00 = 2'b00;
    localparam dst_t DST_01 = 2'b01;
    localparam dst_t DST_10 = 2'b10;
    localparam dst_t DST_11 = 2'b11;

    localparam int NUM_OUT = 4;

endpackage

// File: rtl/demux4_slot.sv
// Single-entry output holding slot: data register plus valid flag.
// A load in the same cycle as a drain keeps the slot full with new data.
module demux4_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= din;
        end else if (drain) begin
            // data is left in place so q holds its last value
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer with per-destination holding slots.
// Define DEMUX4_BUF_CNT_EN to add saturating accepted-beat counters.
module demux4_buf
    import demux4_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef DEMUX4_BUF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  dst_t             in_dst,
    output logic [WIDTH-1:0] q00,
    output logic [WIDTH-1:0] q01,
    output logic [WIDTH-1:0] q10,
    output logic [WIDTH-1:0] q11,
    output logic [3:0]       q_valid,
    input  logic [3:0]       q_ready
`ifdef DEMUX4_BUF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt00,
    output logic [CNT_W-1:0] cnt01,
    output logic [CNT_W-1:0] cnt10,
    output logic [CNT_W-1:0] cnt11
`endif
);

    logic               acc;
    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] drn;
    logic [WIDTH-1:0]   qa [NUM_OUT];

    // only the addressed slot gates acceptance
    assign in_ready = ~reset & ~flush
                    & (~q_valid[in_dst] | q_ready[in_dst]);
    assign acc = in_valid & in_ready;
    assign drn = q_valid & q_ready;

    always_comb begin
        load = '0;
        if (acc) begin
            unique case (in_dst)
                DST_00: load[0] = 1'b1;
                DST_01: load[1] = 1'b1;
                DST_10: load[2] = 1'b1;
                DST_11: load[3] = 1'b1;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        demux4_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk  (clk),
            .reset(reset),
            .flush(flush),
            .load (load[i]),
            .drain(drn[i]),
            .din  (in_data),
            .q    (qa[i]),
            .valid(q_valid[i])
        );
    end

    assign q00 = qa[0];
    assign q01 = qa[1];
    assign q10 = qa[2];
    assign q11 = qa[3];

`ifdef DEMUX4_BUF_CNT_EN
    logic [CNT_W-1:0] cnt [NUM_OUT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (load[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    assign cnt00 = cnt[0];
    assign cnt01 = cnt[1];
    assign cnt10 = cnt[2];
    assign cnt11 = cnt[3];
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// Scoreboard bench for demux4_buf: driver pushes accepted words per slot,
// monitor pops and compares on every drain. Counter checks under DEMUX4_BUF_CNT_EN.
module tb_demux4_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_dst;
    logic [31:0] q00, q01, q10, q11;
    logic [3:0]  q_valid;
    logic [3:0]  q_ready;
`ifdef DEMUX4_BUF_CNT_EN
    logic [1:0]  cnt00, cnt01, cnt10, cnt11;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] sbq [4][$];
    logic [3:0]  full = 4'b0000;
    bit          run = 1'b0;

    always #5 clk = ~clk;

    demux4_buf #(
        .WIDTH(32)
`ifdef DEMUX4_BUF_CNT_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_dst  (in_dst),
        .q00     (q00),
        .q01     (q01),
        .q10     (q10),
        .q11     (q11),
        .q_valid (q_valid),
        .q_ready (q_ready)
`ifdef DEMUX4_BUF_CNT_EN
        ,
        .cnt00   (cnt00),
        .cnt01   (cnt01),
        .cnt10   (cnt10),
        .cnt11   (cnt11)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // driver-side model: occupancy, in_ready prediction, expected pushes
    always @(negedge clk) begin
        if (run) begin
            logic exp_rdy;
            logic acc;
            chk("q_valid", {28'd0, q_valid}, {28'd0, full});
            exp_rdy = ~reset & ~flush
                    & (~full[in_dst] | q_ready[in_dst]);
            if (in_valid || reset || flush)
                chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            acc = in_valid & exp_rdy;
            if (reset || flush) begin
                full = 4'b0000;
                for (int i = 0; i < 4; i++) sbq[i].delete();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (acc && in_dst == 2'(i)) begin
                        full[i] = 1'b1;
                        sbq[i].push_back(in_data);
                    end else if (q_ready[i]) begin
                        full[i] = 1'b0;
                    end
                end
            end
        end
    end

    // monitor: every drain consumes the oldest expected word of that slot
    always @(negedge clk) begin
        if (run && !reset && !flush) begin
            logic [31:0] qv [4];
            qv[0] = q00; qv[1] = q01; qv[2] = q10; qv[3] = q11;
            for (int i = 0; i < 4; i++) begin
                if (q_valid[i] && q_ready[i]) begin
                    if (sbq[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL drain_unexpected slot%0d: got %h want none",
                                 i, qv[i]);
                    end else begin
                        chk($sformatf("drain_q%0d", i), qv[i],
                            sbq[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] d,
                        input logic [31:0] w, input logic [3:0] r,
                        input logic f, input logic rs);
        in_valid = v;
        in_dst   = d;
        in_data  = w;
        q_ready  = r;
        flush    = f;
        reset    = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_dst = '0; q_ready = '0;
        @(posedge clk); #1;
        run = 1'b1;

        // reset held with a pending word
        step(1, 2, 32'hDEAD_BEEF, 4'b1111, 0, 1);
        step(1, 2, 32'hDEAD_BEEF, 4'b1111, 0, 1);
        chk("rst_q10", q10, 32'h0);
        chk("rst_valid", {28'd0, q_valid}, 32'h0);

        // routing
        step(1, 0, 32'hAAAA_0000, 4'b1111, 0, 0);
        chk("route_q00", q00, 32'hAAAA_0000);
        step(1, 3, 32'h0000_BBBB, 4'b1111, 0, 0);
        chk("route_q11", q11, 32'h0000_BBBB);
        step(0, 0, 32'h0, 4'b1111, 0, 0);

        // backpressure on slot 1, slot 2 unaffected
        step(1, 1, 32'h11, 4'b1101, 0, 0);
        step(1, 1, 32'h22, 4'b1101, 0, 0);
        chk("bp_hold_q01", q01, 32'h11);
        step(1, 2, 32'h33, 4'b1101, 0, 0);
        chk("bp_q10", q10, 32'h33);
        chk("bp_still_q01", q01, 32'h11);
        step(1, 1, 32'h22, 4'b1111, 0, 0);
        chk("bp_new_q01", q01, 32'h22);
        step(0, 0, 32'h0, 4'b1111, 0, 0);

        // streaming into slot 2
        for (int k = 0; k < 8; k++) begin
            step(1, 2, 32'h0100_0000 + 32'(k), 4'b0100, 0, 0);
            chk("stream_q10", q10, 32'h0100_0000 + 32'(k));
        end
        step(0, 0, 32'h0, 4'b1111, 0, 0);

        // fill all slots, then flush with no consumers ready
        step(1, 0, 32'hF0, 4'b0000, 0, 0);
        step(1, 1, 32'hF1, 4'b0000, 0, 0);
        step(1, 2, 32'hF2, 4'b0000, 0, 0);
        step(1, 3, 32'hF3, 4'b0000, 0, 0);
        chk("fill_valid", {28'd0, q_valid}, 32'hF);
        step(1, 0, 32'hF9, 4'b0000, 1, 0);
        chk("flush_valid", {28'd0, q_valid}, 32'h0);
        chk("flush_keep_q11", q11, 32'hF3);
        step(0, 0, 32'h0, 4'b1111, 0, 0);

`ifdef DEMUX4_BUF_CNT_EN
        begin
            logic [1:0] exp_cnt [5];
            exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            step(0, 0, 32'h0, 4'b1111, 0, 1);
            for (int k = 0; k < 5; k++) begin
                step(1, 0, 32'h500 + 32'(k), 4'b1111, 0, 0);
                chk("cnt00", {30'd0, cnt00}, {30'd0, exp_cnt[k]});
            end
            chk("cnt_others", {26'd0, cnt01, cnt10, cnt11}, 32'h0);
            step(0, 0, 32'h0, 4'b1111, 0, 0);
        end
`endif

        step(0, 0, 32'h0, 4'b1111, 0, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("leftover_q%0d", i), 32'(sbq[i].size()), 32'h0);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
